// File: rtl/fb_flip_if.sv
// Flip-request and base-update handshakes between the register side,
// the flip scheduler and the framebuffer DMA configuration port.
interface fb_flip_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_base_i;
    logic              upd_valid_o;
    logic              upd_ready_i;
    logic [ADDR_W-1:0] upd_base_o;

    // Scheduler side
    modport slave (
        input  req_valid_i,
        input  req_base_i,
        input  upd_ready_i,
        output req_ready_o,
        output upd_valid_o,
        output upd_base_o
    );

    // Requester / DMA side
    modport master (
        output req_valid_i,
        output req_base_i,
        output upd_ready_i,
        input  req_ready_o,
        input  upd_valid_o,
        input  upd_base_o
    );
endinterface

// File: rtl/fb_flip_scheduler.sv
// Page-flip scheduler: queues framebuffer base flips and releases each one to the
// DMA configuration handshake only on a frame boundary (or immediately when idle).
module fb_flip_scheduler #(
    parameter int unsigned       DEPTH      = 2,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_BASE = '0
) (
    input  logic              clk,
    input  logic              rst,
    fb_flip_if.slave          bus,
    input  logic              immediate_i,
    input  logic              framefinish_i,
    input  logic              irq_clr_i,
    output logic [ADDR_W-1:0] cur_base_o,
    output logic              flip_done_o,
    output logic              irq_o,
    output logic [2:0]        pending_o,
    output logic [15:0]       missed_o
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned MISS_W = 16;

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              upd_valid_q, upd_valid_d;
    logic [ADDR_W-1:0] upd_base_q, upd_base_d;
    logic [ADDR_W-1:0] cur_base_q, cur_base_d;
    logic              done_q, done_d;
    logic              irq_q, irq_d;
    logic [MISS_W-1:0] missed_q, missed_d;

    logic push;
    logic pop;
    logic handshake;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            upd_valid_q <= 1'b0;
            upd_base_q  <= '0;
            cur_base_q  <= RESET_BASE;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            missed_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            upd_valid_q <= upd_valid_d;
            upd_base_q  <= upd_base_d;
            cur_base_q  <= cur_base_d;
            done_q      <= done_d;
            irq_q       <= irq_d;
            missed_q    <= missed_d;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.req_base_i;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        upd_valid_d = upd_valid_q;
        upd_base_d  = upd_base_q;
        cur_base_d  = cur_base_q;
        missed_d    = missed_q;
        pop         = 1'b0;
        handshake   = 1'b0;
        push        = bus.req_valid_i & ready_q;

        case (state_q)
            S_IDLE: begin
                // Frame pulses are ignored here; a push arms for the next frame
                if (push || (count_q != '0)) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (framefinish_i || immediate_i) begin
                    pop         = 1'b1;
                    upd_base_d  = mem[rd_ptr_q];
                    upd_valid_d = 1'b1;
                    state_d     = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (framefinish_i && (missed_q != MISS_MAX)) begin
                    missed_d = missed_q + MISS_W'(1);
                end
                if (bus.upd_ready_i) begin
                    handshake   = 1'b1;
                    upd_valid_d = 1'b0;
                    cur_base_d  = upd_base_q;
                    state_d     = (push || (count_q != '0)) ? S_ARMED : S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                upd_valid_d = 1'b0;
            end
        endcase

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ready_d = (count_d != DEPTH_C);
        done_d  = handshake;
        // Set (handshake or the done pulse itself) wins over a clear
        irq_d   = handshake | done_q | (irq_q & ~irq_clr_i);
    end

    assign bus.req_ready_o = ready_q;
    assign bus.upd_valid_o = upd_valid_q;
    assign bus.upd_base_o  = upd_base_q;
    assign cur_base_o      = cur_base_q;
    assign flip_done_o     = done_q;
    assign irq_o           = irq_q;
    assign pending_o       = count_q;
    assign missed_o        = missed_q;

endmodule

// File: tb/tb_fb_flip_scheduler.sv
// Scoreboard bench for fb_flip_scheduler: directed test-plan scenarios plus
// randomized traffic checked against a transaction-level flip model.
module tb_fb_flip_scheduler;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned ADDR_W     = 32;
    localparam logic [31:0] RESET_BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        immediate = 1'b0;
    logic        ff_man = 1'b0;
    logic        ff_auto = 1'b0;
    logic        framefinish;
    logic        irq_clr = 1'b0;
    logic [31:0] cur_base;
    logic        flip_done;
    logic        irq;
    logic [2:0]  pending;
    logic [15:0] missed;

    bit ff_en = 1'b0;
    int frame_cnt = 0;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] sb[$];
    bit          m_offer = 1'b0;
    logic [31:0] m_offer_base = '0;
    logic [31:0] m_cur = RESET_BASE;
    bit          m_done = 1'b0;
    bit          m_irq = 1'b0;
    int          m_missed = 0;
    bit          m_push;
    bit          m_dn;

    always #5 clk = ~clk;
    assign framefinish = ff_man | ff_auto;

    fb_flip_if #(.ADDR_W(ADDR_W)) bus ();

    fb_flip_scheduler #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .RESET_BASE(RESET_BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .immediate_i  (immediate),
        .framefinish_i(framefinish),
        .irq_clr_i    (irq_clr),
        .cur_base_o   (cur_base),
        .flip_done_o  (flip_done),
        .irq_o        (irq),
        .pending_o    (pending),
        .missed_o     (missed)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: a flip may leave the queue on a frame pulse (or
    // immediate) only when no update is outstanding and it was queued earlier.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            sb.delete();
            m_offer      = 1'b0;
            m_offer_base = '0;
            m_cur        = RESET_BASE;
            m_done       = 1'b0;
            m_irq        = 1'b0;
            m_missed     = 0;
        end else begin
            m_push = bus.req_valid_i && (mq.size() < DEPTH);
            m_dn   = 1'b0;
            if (m_offer) begin
                if (framefinish && m_missed < 65535) m_missed++;
                if (bus.upd_ready_i) begin
                    m_cur   = m_offer_base;
                    m_dn    = 1'b1;
                    m_offer = 1'b0;
                end
            end else if (mq.size() > 0 && (framefinish || immediate)) begin
                m_offer      = 1'b1;
                m_offer_base = mq.pop_front();
            end
            m_irq  = m_dn || m_done || (m_irq && !irq_clr);
            m_done = m_dn;
            if (m_push) begin
                mq.push_back(bus.req_base_i);
                sb.push_back(bus.req_base_i);
            end
        end
    end

    // Monitor: per-cycle output comparison and handshake-ordered scoreboard
    always @(negedge clk) begin
        logic [31:0] exp_base;
        chk("upd_valid", 64'(bus.upd_valid_o), 64'(m_offer));
        chk("upd_base", 64'(bus.upd_base_o), 64'(m_offer_base));
        chk("req_ready", 64'(bus.req_ready_o), 64'(mq.size() < DEPTH));
        chk("pending", 64'(pending), 64'(mq.size()));
        chk("cur_base", 64'(cur_base), 64'(m_cur));
        chk("flip_done", 64'(flip_done), 64'(m_done));
        chk("irq", 64'(irq), 64'(m_irq));
        chk("missed", 64'(missed), 64'(m_missed));
        if (!rst && bus.upd_valid_o && bus.upd_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: actual=handshake required=no_update at %0t", $time);
            end else begin
                exp_base = sb.pop_front();
                chk("sb_order", 64'(bus.upd_base_o), 64'(exp_base));
            end
        end
    end

    // Free-running frame generator, period 8
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ff_auto   = ff_en && (frame_cnt == 7);
            frame_cnt = (frame_cnt + 1) % 8;
        end
    end

    initial begin
        int  vcnt;
        bit  got;
        bus.req_valid_i = 1'b0;
        bus.req_base_i  = '0;
        bus.upd_ready_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Single flip
        bus.upd_ready_i = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_base_i  = 32'h8000_0000;
        tick();
        bus.req_valid_i = 1'b0;
        repeat (4) tick();
        ff_man = 1'b1;
        tick();
        ff_man = 1'b0;
        vcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.upd_valid_o) vcnt++;
            tick();
        end
        chk("s1_valid_cycles", 64'(vcnt), 64'd1);
        chk("s1_cur", 64'(cur_base), 64'h8000_0000);
        chk("s1_irq", 64'(irq), 64'd1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;

        // Queue full: A, B accepted, C stalls until A leaves the queue
        bus.req_valid_i = 1'b1;
        bus.req_base_i  = 32'hA000_0000;
        tick();
        bus.req_base_i  = 32'hB000_0000;
        tick();
        bus.req_base_i  = 32'hC000_0000;
        tick();
        @(negedge clk);
        chk("full_ready", 64'(bus.req_ready_o), 64'd0);
        chk("full_pending", 64'(pending), 64'd2);
        ff_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        tick();
        bus.req_valid_i = 1'b0;
        chk("full_c_accepted", 64'(got), 64'd1);
        repeat (40) tick();
        ff_en = 1'b0;
        chk("full_last_cur", 64'(cur_base), 64'hC000_0000);

        // Missed frames while DMA holds off
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.upd_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_base_i  = 32'hD000_0000;
        tick();
        bus.req_valid_i = 1'b0;
        ff_man = 1'b1;
        tick();
        ff_man = 1'b0;
        repeat (3) begin
            tick();
            ff_man = 1'b1;
            tick();
            ff_man = 1'b0;
        end
        tick();
        @(negedge clk);
        chk("miss_count", 64'(missed), 64'd3);
        chk("miss_base_held", 64'(bus.upd_base_o), 64'hD000_0000);
        chk("miss_cur_unchanged", 64'(cur_base), 64'(RESET_BASE));
        tick();
        bus.upd_ready_i = 1'b1;
        repeat (2) tick();
        chk("miss_cur_after", 64'(cur_base), 64'hD000_0000);

        // Push into empty queue coincident with a frame pulse
        bus.req_valid_i = 1'b1;
        bus.req_base_i  = 32'hE000_0000;
        ff_man = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        ff_man = 1'b0;
        vcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.upd_valid_o) vcnt++;
            tick();
        end
        chk("ff_same_cycle_no_update", 64'(vcnt), 64'd0);
        ff_man = 1'b1;
        tick();
        ff_man = 1'b0;
        repeat (3) tick();

        // Immediate release: update two cycles after the push
        bus.req_valid_i = 1'b1;
        bus.req_base_i  = 32'hF000_0000;
        immediate = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        @(negedge clk);
        chk("imm_valid", 64'(bus.upd_valid_o), 64'd1);
        chk("imm_base", 64'(bus.upd_base_o), 64'hF000_0000);
        tick();
        immediate = 1'b0;
        repeat (2) tick();

        // Interrupt clear colliding with the done pulse
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_base_i  = 32'h1234_5678;
        tick();
        bus.req_valid_i = 1'b0;
        ff_man = 1'b1;
        tick();
        ff_man = 1'b0;
        tick();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        @(negedge clk);
        chk("irq_set_wins", 64'(irq), 64'd1);
        repeat (2) tick();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        @(negedge clk);
        chk("irq_cleared", 64'(irq), 64'd0);

        // Reset while an update is outstanding with two entries queued
        bus.upd_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_base_i  = 32'h2000_0000;
        tick();
        bus.req_valid_i = 1'b0;
        ff_man = 1'b1;
        tick();
        ff_man = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_base_i  = 32'h3000_0000;
        tick();
        bus.req_base_i  = 32'h4000_0000;
        tick();
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_pre_pending", 64'(pending), 64'd2);
        chk("rst_pre_valid", 64'(bus.upd_valid_o), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(bus.upd_valid_o), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_cur", 64'(cur_base), 64'(RESET_BASE));
        chk("rst_missed", 64'(missed), 64'd0);
        chk("rst_ready", 64'(bus.req_ready_o), 64'd1);
        tick();

        // Randomized traffic
        repeat (3000) begin
            bus.req_valid_i = 1'($urandom_range(0, 1));
            bus.req_base_i  = $urandom;
            bus.upd_ready_i = ($urandom_range(0, 3) != 0);
            ff_man          = ($urandom_range(0, 7) == 0);
            immediate       = ($urandom_range(0, 15) == 0);
            irq_clr         = ($urandom_range(0, 7) == 0);
            rst             = ($urandom_range(0, 299) == 0);
            tick();
        end
        bus.req_valid_i = 1'b0;
        bus.upd_ready_i = 1'b1;
        ff_man    = 1'b0;
        immediate = 1'b0;
        irq_clr   = 1'b0;
        rst       = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
